// File: rtl/envelope_sd_dac.sv
// Attack/sustain/release envelope on an offset-binary sample, then a first-order 1-bit sigma-delta DAC.
// Optional build macro SD_DITHER_EN adds a 16-bit Galois LFSR carry-in dither to the modulator.
module envelope_sd_dac #(
  parameter int RATE_DIV     = 1024,
  parameter int ATTACK_STEP  = 4,
  parameter int RELEASE_STEP = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sample_in,
  input  logic       gate,
  output logic       dac_out,
  output logic [7:0] env_level,
  output logic [1:0] env_state,
  output logic       active
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ATTACK  = 2'd1,
    SUSTAIN = 2'd2,
    RELEASE = 2'd3
  } state_e;

  localparam int              CNT_W   = $clog2(RATE_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RATE_DIV - 1);
  localparam logic [8:0]      ATT_INC = 9'(ATTACK_STEP);
  localparam logic [7:0]      REL_DEC = 8'(RELEASE_STEP);

  // Envelope tick: free-running divider, never paused.
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick;

  always_comb begin
    tick  = (cnt_q == CNT_MAX);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  state_e     state_q;
  logic [7:0] level_q;
  logic [8:0] att_sum;
  logic [7:0] att_level, rel_level;

  // Saturating step results; only committed on a tick without a gate change.
  always_comb begin
    att_sum   = {1'b0, level_q} + ATT_INC;
    att_level = att_sum[8] ? 8'hFF : att_sum[7:0];
    rel_level = (level_q > REL_DEC) ? level_q - REL_DEC : 8'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      level_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          level_q <= '0;
          if (gate) state_q <= ATTACK;
        end
        ATTACK: begin
          if (!gate) begin
            state_q <= RELEASE;
          end else if (tick) begin
            level_q <= att_level;
            if (att_level == 8'hFF) state_q <= SUSTAIN;
          end
        end
        SUSTAIN: begin
          level_q <= 8'hFF;
          if (!gate) state_q <= RELEASE;
        end
        RELEASE: begin
          if (gate) begin
            state_q <= ATTACK;
          end else if (tick) begin
            level_q <= rel_level;
            if (rel_level == 8'd0) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Datapath: sample register -> envelope scaling -> sigma-delta accumulator.
  logic [7:0]         sample_q, sample_d;
  logic [7:0]         scaled_q, scaled_d;
  logic [7:0]         acc_q, acc_d;
  logic               dac_q, dac_d;
  logic signed [7:0]  s8;
  logic signed [16:0] s_ext, l_ext, prod;
  logic [8:0]         sum;
  logic               unused_prod;

`ifdef SD_DITHER_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= 16'hACE1;
    else        lfsr_q <= lfsr_d;
  end
`endif

  always_comb begin
    sample_d = sample_in;
    // Offset-binary minus 128 is just an MSB flip in two's complement.
    s8       = {~sample_q[7], sample_q[6:0]};
    s_ext    = {{9{s8[7]}}, s8};
    l_ext    = {9'd0, level_q};
    prod     = s_ext * l_ext;
    // prod[15:8] is floor(prod/256) in 8-bit two's complement; +128 restores offset-binary.
    scaled_d = prod[15:8] + 8'd128;
`ifdef SD_DITHER_EN
    sum      = {1'b0, acc_q} + {1'b0, scaled_q} + {8'd0, lfsr_q[0]};
`else
    sum      = {1'b0, acc_q} + {1'b0, scaled_q};
`endif
    acc_d    = sum[7:0];
    dac_d    = sum[8];
  end

  assign unused_prod = ^{prod[16], prod[7:0]};

  // NOTE: all datapath registers reset to mid-scale/zero so the bitstream restarts at a known phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_q <= 8'd128;
      scaled_q <= 8'd128;
      acc_q    <= 8'd0;
      dac_q    <= 1'b0;
    end else begin
      sample_q <= sample_d;
      scaled_q <= scaled_d;
      acc_q    <= acc_d;
      dac_q    <= dac_d;
    end
  end

  assign dac_out   = dac_q;
  assign env_level = level_q;
  assign env_state = state_q;
  assign active    = (state_q != IDLE);

endmodule

// File: tb/tb_envelope_sd_dac.sv
// Scoreboard bench for envelope_sd_dac: a reference model queues expected outputs per clock,
// a monitor compares them; directed sequences check the envelope and density boundary cases.
module tb_envelope_sd_dac;

  localparam int RD = 4;
  localparam int AS = 4;
  localparam int RS = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] sample_in = 8'd128;
  logic       gate = 1'b0;
  logic       dac_out;
  logic [7:0] env_level;
  logic [1:0] env_state;
  logic       active;

  always #5 clk = ~clk;

  envelope_sd_dac #(
    .RATE_DIV    (RD),
    .ATTACK_STEP (AS),
    .RELEASE_STEP(RS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sample_in(sample_in),
    .gate     (gate),
    .dac_out  (dac_out),
    .env_level(env_level),
    .env_state(env_state),
    .active   (active)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic int floor_div256(input int p);
    int q;
    q = p / 256;
    if (p < 0 && q * 256 != p) q--;
    return q;
  endfunction

  // ---------------- reference model ----------------
  typedef struct packed {
    logic       dac;
    logic [7:0] level;
    logic [1:0] state;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  int          m_cnt = 0, m_state = 0, m_level = 0;
  int          m_sample = 128, m_scaled = 128, m_acc = 0, m_dac = 0;
  int          total, sc;
  bit          m_tick;
  logic [15:0] m_lfsr = 16'hACE1;

  always @(negedge rst_n) begin
    m_cnt = 0; m_state = 0; m_level = 0;
    m_sample = 128; m_scaled = 128; m_acc = 0; m_dac = 0;
    m_lfsr = 16'hACE1;
    exp_q.delete();
  end

  always @(posedge clk) begin
    if (rst_n) begin
      m_tick = (m_cnt == RD - 1);
      m_cnt  = (m_cnt + 1) % RD;
      total  = m_acc + m_scaled;
`ifdef SD_DITHER_EN
      total  = total + int'(m_lfsr[0]);
      m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
`endif
      m_dac    = (total >= 256) ? 1 : 0;
      m_acc    = total % 256;
      sc       = 128 + floor_div256((m_sample - 128) * m_level);
      m_scaled = sc;
      m_sample = int'(sample_in);
      case (m_state)
        0: if (gate) m_state = 1;
        1: begin
          if (!gate) m_state = 3;
          else if (m_tick) begin
            m_level = (m_level + AS > 255) ? 255 : m_level + AS;
            if (m_level == 255) m_state = 2;
          end
        end
        2: if (!gate) m_state = 3;
        default: begin
          if (gate) m_state = 1;
          else if (m_tick) begin
            m_level = (m_level - RS < 0) ? 0 : m_level - RS;
            if (m_level == 0) m_state = 0;
          end
        end
      endcase
      exp_q.push_back('{dac: m_dac[0], level: m_level[7:0], state: m_state[1:0]});
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_dac_out", dac_out, e.dac);
      check("sb_env_level", env_level, e.level);
      check("sb_env_state", env_state, e.state);
      check("sb_active", active, e.state != 2'd0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset(input logic g);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    gate = g;
    sample_in = 8'd128;
    #1;
    check("rst_dac_out", dac_out, 0);
    check("rst_env_level", env_level, 0);
    check("rst_env_state", env_state, 0);
    check("rst_active", active, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic count_ones(input logic [7:0] s, output int ones);
    sample_in = s;
    repeat (4) @(negedge clk);
    ones = 0;
    repeat (256) begin
      @(negedge clk);
      ones += int'(dac_out);
    end
  endtask

  task automatic wait_state(input logic [1:0] st, input int budget, input string name);
    int n;
    n = 0;
    while (env_state != st && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (env_state != st) check(name, env_state, st);
  endtask

  int ones, n, decs, prev, rs;
  bit done;

  initial begin
    #1;
    check("init_dac_out", dac_out, 0);
    check("init_env_state", env_state, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;

    // Envelope at zero: any sample scales to exactly mid-scale.
    ones = 0;
    for (int i = 0; i < 260; i++) begin
      @(negedge clk);
      sample_in = 8'($urandom);
      if (i >= 4) ones += int'(dac_out);
    end
`ifndef SD_DITHER_EN
    check("idle_density", ones, 128);
`endif

    // Attack from a freshly reset divider.
    do_reset(1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 4) check("attack_first_tick", env_level, 4);
      if (n == 8) check("attack_second_tick", env_level, 8);
    end while (env_state != 2'd2 && n < 400);
    check("attack_clocks_to_sustain", n, 256);
    check("attack_peak", env_level, 255);

    // Density in SUSTAIN.
    count_ones(8'd255, ones);
`ifndef SD_DITHER_EN
    check("density_255", ones, 254);
`endif
    count_ones(8'd0, ones);
`ifdef SD_DITHER_EN
    check("dither_nonzero", ones > 0, 1);
`else
    check("density_0", ones, 0);
`endif
    rs = int'($urandom_range(0, 255));
    count_ones(8'(rs), ones);
`ifndef SD_DITHER_EN
    check("density_rand", ones, 128 + floor_div256((rs - 128) * 255));
`endif

    // Reset mid-SUSTAIN, then mid-scale alternation.
    do_reset(1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
`ifndef SD_DITHER_EN
      check("post_reset_alt", dac_out, i % 2);
`endif
    end

    // Release from SUSTAIN.
    gate = 1'b1;
    wait_state(2'd2, 400, "to_sustain_1");
    gate = 1'b0;
    prev = 255; decs = 0; done = 0;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      if (int'(env_level) != prev) begin
        if (decs == 0) check("release_first", env_level, 253);
        decs++;
        prev = int'(env_level);
        if (env_level == 8'd0) begin
          check("release_idle_state", env_state, 0);
          check("release_active_low", active, 0);
          done = 1;
        end
      end
    end
    check("release_done", done, 1);
    check("release_steps", decs, 128);

    // Re-trigger at 101 on an edge that is also a tick.
    gate = 1'b1;
    wait_state(2'd2, 400, "to_sustain_2");
    gate = 1'b0;
    done = 0;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      if (env_level == 8'd101) done = 1;
    end
    check("reach_101", done, 1);
    repeat (3) @(negedge clk);
    gate = 1'b1;
    @(negedge clk);
    check("retrig_state", env_state, 1);
    check("retrig_no_step", env_level, 101);
    n = 0;
    while (env_level == 8'd101 && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("retrig_next", env_level, 105);

    // Randomized traffic against the scoreboard.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      sample_in = 8'($urandom);
      if ($urandom_range(0, 299) == 0) gate = ~gate;
    end
    gate = 1'b0;
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/envelope_sd_dac.md
Name: envelope_sd_dac

Overview:
- Downstream output stage for the sine synthesizer.
- Consumes the synth's 8-bit offset-binary sample (128 = silence) and a note gate (any key held).
- Applies an attack/sustain/release amplitude envelope, then converts the scaled sample to a 1-bit first-order sigma-delta stream.
- The 1-bit stream drives one pad through an external RC filter.

Parameters:
- RATE_DIV, 1024: clocks per envelope tick; must be >= 2.
- ATTACK_STEP, 4: envelope increment per tick in ATTACK; range 1..255.
- RELEASE_STEP, 2: envelope decrement per tick in RELEASE; range 1..255.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- sample_in  input  8  offset-binary sample from the synth, sampled every clk
- gate  input  1  note held (OR of key inputs); level-sensitive
- dac_out  output  1  sigma-delta bitstream, registered
- env_level  output  8  current envelope level, 0..255
- env_state  output  2  0=IDLE, 1=ATTACK, 2=SUSTAIN, 3=RELEASE
- active  output  1  high when env_state != IDLE

Behaviour:
- Reset (asynchronous, rst_n low) forces the following; assertion mid-operation aborts immediately, no fade-out:
  - env_state=IDLE, env_level=0
  - tick counter=0
  - sample register=128, scaled register=128
  - accumulator=0, dac_out=0
- Tick counter: free-running 0..RATE_DIV-1, then wraps to 0. Tick is the cycle with count==RATE_DIV-1. Tick never pauses, including in IDLE.
- FSM (gate sampled at each clk edge):
  - IDLE: gate=1 -> ATTACK. Level stays 0.
  - ATTACK:
    - gate=0 -> RELEASE; no level change that edge.
    - Otherwise, on tick: level = min(255, level + ATTACK_STEP).
    - If the result is 255 -> SUSTAIN on the same edge.
  - SUSTAIN: level held at 255; gate=0 -> RELEASE.
  - RELEASE:
    - gate=1 -> ATTACK, resuming from the current level (no restart from 0).
    - Otherwise, on tick: level = max(0, level - RELEASE_STEP).
    - If the result is 0 -> IDLE on the same edge.
- Gate edge coincident with a tick: the state change wins; no step is applied on that edge.
- Datapath pipeline:
  - Stage 1: sample register <= sample_in.
  - Stage 2: s = sample_reg - 128 (9-bit signed); p = s * env_level (17-bit signed); scaled <= 128 + (p >>> 8), arithmetic shift, floor rounding. Result range 0..254; env_level=0 gives exactly 128.
  - Stage 3: {carry, acc} <= acc + scaled (9-bit sum); dac_out <= carry.
- Latency: sample_in change to first affected dac_out bit is 3 clocks. env_level change to first affected dac_out bit is 2 clocks.
- Ones density of dac_out over 256 clocks equals scaled exactly (scaled/256), for constant input starting from acc=0.

Optional Feature:
- Macro: SD_DITHER_EN.
- Defined:
  - 16-bit Galois LFSR, taps 0xB400, reset seed 0xACE1, advances every clk.
  - lfsr[0] is added as a carry-in to the stage-3 sum, so sum = acc + scaled + lfsr[0].
  - Breaks idle tones; long-run density rises by about 0.5/256.
- Not defined:
  - No LFSR logic is generated; stage 3 is exactly as in Behaviour.
  - Density is exact.

Test Plan:
- Reset mid-SUSTAIN (RATE_DIV=4): assert rst_n low for 1 clk -> env_state=0, env_level=0, dac_out=0 immediately; after release, with sample_in=128 and gate=0, dac_out = 0,1,0,1... starting 3 clocks later.
- Attack (RATE_DIV=4, ATTACK_STEP=4): gate=1 held -> env_level 4,8,...,252 on successive ticks; 64th tick gives 255 and env_state=2 on the same edge (256 clocks after gate).
- Release: from SUSTAIN, gate=0 (RELEASE_STEP=2) -> 253,251,...,1, then 0 with env_state=0 on the 128th tick; active falls on the same edge.
- Re-trigger: in RELEASE at level 101, gate=1 -> ATTACK next edge; next tick gives 105; no step on the gate edge even if coincident with a tick.
- Density: SUSTAIN, sample_in=255 -> scaled=254, exactly 254 ones per 256 clocks; sample_in=0 -> scaled=0, dac_out constant 0; env=0 with any sample -> 128 ones per 256.
- SD_DITHER_EN build: SUSTAIN, sample_in=0 -> nonzero ones count; dac_out bit-exact against a reference model seeded with 0xACE1.
